program_counter_stack: RTL and testbench
========================================

# program_counter_stack

Parametrised program counter with a hardware return-address stack: the next-generation PC for the ASAP CPU. It holds the current instruction address and drives it onto the shared tri-state bus on request. It loads jump targets from the bus, increments on step, and supports subroutine call/return through an internal LIFO of return addresses. Overflow and underflow are reported through sticky error flags for the control unit.

## Interface
- `WIDTH`, default 8: address and bus width in bits (≥2).
- `DEPTH`, default 4: return-stack entries (≥1).
- `SPW`, default `$clog2(DEPTH+1)`: stack-pointer width (derived; do not override).

Ports:
- `clk` input 1: system clock; all state updates on the falling edge.
- `rst` input 1: asynchronous, active-high reset.
- `ie` input 1: load PC from `bus` (jump).
- `oe` input 1: drive PC onto `bus`.
- `step` input 1: increment PC.
- `call` input 1: push PC+1, then load PC from `bus`.
- `ret` input 1: pop the top of stack into PC.
- `clr_err` input 1: clear the sticky error flags.
- `data` output WIDTH: current PC (registered).
- `bus` inout WIDTH: shared bus; driven with `data` when `oe`=1, otherwise high-Z.
- `sp` output SPW: number of valid stack entries (0..DEPTH).
- `empty` output 1: `sp`==0.
- `full` output 1: `sp`==DEPTH.
- `overflow` output 1: sticky; set when `call` is attempted while full.
- `underflow` output 1: sticky; set when `ret` is attempted while empty.

## Operation
- `bus` = `oe` ? `data` : all-Z. This is purely combinational; `oe` has no effect on state.
- One action per falling edge, chosen by fixed priority (highest first):
  - `ret`: if not empty, `data` ← stack[sp-1] and `sp` ← `sp`-1. If empty, `data` is unchanged and `underflow` ← 1.
  - `call`: if not full, stack[sp] ← `data`+1 (mod 2^WIDTH), `sp` ← `sp`+1, `data` ← `bus`. If full, there is no push, no load, `data` is unchanged, and `overflow` ← 1.
  - `ie`: `data` ← `bus`.
  - `step`: `data` ← `data`+1, wrapping from 2^WIDTH−1 to 0.
  - None asserted: hold.
- Lower-priority requests on the same edge are discarded, not queued. Example: `ret` with `step` gives a pop only.
- `clr_err`: clears both flags on the edge. Setting takes precedence: if an error event and `clr_err` occur on the same edge, the flag ends up 1.
- Stack contents are not reset. Only `sp` and the flags are reset. Entries at or above `sp` are don't-care.
- `empty` and `full` are combinational decodes of `sp`.

## Timing
- Reset (`rst`=1, asynchronous, takes effect immediately without a clock edge): `data`=0, `sp`=0, `overflow`=0, `underflow`=0, so `empty`=1 and `full`=0. `bus` still follows `oe`, driving 0 during reset if `oe`=1.
- While `rst` is high, all other inputs are ignored. After deassertion, the first falling edge performs normal operation.
- Reset asserted mid-call or mid-return (between edges) aborts the operation; no partial push or pop survives.
- Latency: every action is visible on `data`, `sp` and the flags immediately after the falling edge on which it was sampled. Control inputs and `bus` must be stable around that edge.
- `bus` output follows `oe` and `data` combinationally, with zero cycles of latency.
- A `ret` on the edge immediately after a `call` returns exactly the pushed value.
- Back-to-back calls up to DEPTH are legal. The (DEPTH+1)-th call without an intervening return is the overflow case.

## Test plan
- Reset and step (WIDTH=8): assert `rst` asynchronously mid-cycle → `data`=0, `sp`=0, `empty`=1, with no clock edge needed. Then 256 `step` edges → `data` goes 0,1,…,255,0 (wrap).
- Jump and drive: `bus`=0x3C with `ie`=1 → `data`=0x3C. `oe`=1 with `ie`=0 → `bus` reads 0x3C. `oe`=0 → `bus`=Z.
- Call/return: `data`=0x10, `call` with `bus`=0x80 → `data`=0x80, `sp`=1. Step twice → 0x82. `ret` → `data`=0x11, `sp`=0, `empty`=1.
- Nesting and overflow (DEPTH=4): 4 calls from PCs 0x01/0x21/0x41/0x61 → `full`=1. A 5th call with `bus`=0xF0 → `data` unchanged, `sp`=4, `overflow`=1. Four returns → `data` reads 0x62, 0x42, 0x22, 0x02 in that order.
- Underflow and clear: `ret` with `sp`=0 → `data` held, `underflow`=1 (sticky over later edges). `clr_err` → 0. `clr_err` together with an empty `ret` on the same edge → `underflow` stays 1.
- Priority: `ret`+`call`+`ie`+`step` on one edge with `sp`=1 and top=0x45 → `data`=0x45, `sp`=0. `ie`+`step` with `bus`=0x07 → `data`=0x07.

Source files
------------

// File: rtl/program_counter_stack.sv
// Program counter with a hardware return-address stack.
// Holds the current instruction address, drives it onto the shared
// tri-state bus on request, and supports jump, step, call and return.
// All state changes on the falling edge of clk; reset is asynchronous.
module program_counter_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ie,
  input  logic             oe,
  input  logic             step,
  input  logic             call,
  input  logic             ret,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data,
  inout  wire  [WIDTH-1:0] bus,
  output logic [SPW-1:0]   sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  // Width of a stack-slot index; sp itself needs one extra code for "full".
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Action selected for the coming falling edge, in priority order.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_STEP,
    ACT_LOAD,
    ACT_PUSH,
    ACT_POP,
    ACT_OVF,
    ACT_UNF
  } act_e;

  act_e             act;
  logic [WIDTH-1:0] data_nxt;
  logic [SPW-1:0]   sp_nxt;
  logic             overflow_nxt;
  logic             underflow_nxt;
  logic             push_en;
  logic [SPW-1:0]   sp_dec;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  // Address increment that wraps from all-ones back to zero.
  function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  // Sticky flag update: a new error event wins over a clear on the same edge.
  function automatic logic sticky_next(input logic cur, input logic set_ev,
                                       input logic clr);
    logic r;
    r = cur;
    if (clr)    r = 1'b0;
    if (set_ev) r = 1'b1;
    return r;
  endfunction

  // The bus carries the PC only while oe is high; otherwise it is released.
  assign bus = oe ? data : {WIDTH{1'bz}};

  // Occupancy decodes.
  assign empty = (sp == '0);
  assign full  = (sp == SPW'(DEPTH));

  // Stack slot addressing: push writes at sp, pop reads at sp-1.
  assign sp_dec = sp - SPW'(1);
  assign wr_idx = sp[AW-1:0];
  assign rd_idx = sp_dec[AW-1:0];

  // Fixed-priority action decode: ret > call > ie > step > hold.
  always_comb begin
    act = ACT_HOLD;
    if (ret) begin
      act = empty ? ACT_UNF : ACT_POP;
    end else if (call) begin
      act = full ? ACT_OVF : ACT_PUSH;
    end else if (ie) begin
      act = ACT_LOAD;
    end else if (step) begin
      act = ACT_STEP;
    end
  end

  // Next-state values for the PC, stack pointer and error flags.
  always_comb begin
    data_nxt      = data;
    sp_nxt        = sp;
    push_en       = 1'b0;
    case (act)
      ACT_POP: begin
        data_nxt = stack_mem[rd_idx];
        sp_nxt   = sp_dec;
      end
      ACT_PUSH: begin
        data_nxt = bus;
        sp_nxt   = sp + SPW'(1);
        push_en  = ~rst;
      end
      ACT_LOAD: data_nxt = bus;
      ACT_STEP: data_nxt = inc_wrap(data);
      default:  data_nxt = data;
    endcase
    overflow_nxt  = sticky_next(overflow,  act == ACT_OVF, clr_err);
    underflow_nxt = sticky_next(underflow, act == ACT_UNF, clr_err);
  end

  // Control state: PC, stack pointer and sticky flags, cleared by reset.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      data      <= data_nxt;
      sp        <= sp_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  // Return-address storage; contents are not reset, only sp marks validity.
  always_ff @(negedge clk) begin
    if (push_en) begin
      stack_mem[wr_idx] <= inc_wrap(data);
    end
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench for program_counter_stack (WIDTH=8, DEPTH=4).
// Stimulus computes the expected state with a queue-based stack model and
// pushes it into a scoreboard; a monitor pops and compares after each
// falling edge.
module tb_program_counter_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             ie, oe, step, call, ret, clr_err;
  logic [WIDTH-1:0] drv;
  logic [WIDTH-1:0] data;
  wire  [WIDTH-1:0] bus;
  logic [SPW-1:0]   sp;
  logic             empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [SPW-1:0]   sp;
    logic             ovf;
    logic             unf;
    logic [WIDTH-1:0] bv;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stack[$];
  logic             m_ovf, m_unf;

  // Bench drives the bus whenever the DUT is not driving it.
  assign bus = oe ? {WIDTH{1'bz}} : drv;

  program_counter_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ie(ie), .oe(oe), .step(step), .call(call),
    .ret(ret), .clr_err(clr_err), .data(data), .bus(bus), .sp(sp),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One falling-edge operation: set inputs after the rising edge, update model.
  task automatic op(input logic r, input logic c, input logic i,
                    input logic s, input logic cl, input logic o,
                    input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] bv;
    logic             set_u, set_o;
    exp_t             e;
    @(posedge clk);
    #1;
    ret = r; call = c; ie = i; step = s; clr_err = cl; oe = o; drv = d;
    bv    = o ? m_pc : d;
    set_u = r && (m_stack.size() == 0);
    set_o = !r && c && (m_stack.size() == DEPTH);
    if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
    end else if (c) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back(m_pc + 8'd1);
        m_pc = bv;
      end
    end else if (i) begin
      m_pc = bv;
    end else if (s) begin
      m_pc = m_pc + 8'd1;
    end
    m_unf = set_u | (m_unf & ~cl);
    m_ovf = set_o | (m_ovf & ~cl);
    e.pc  = m_pc;
    e.sp  = SPW'(m_stack.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    e.bv  = o ? m_pc : d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic o, input logic [WIDTH-1:0] d);
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o, d);
  endtask

  // Asynchronous reset asserted between edges while a call is pending.
  task automatic do_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    call = 1'b1; ret = 1'b0; ie = 1'b1; step = 1'b1; oe = 1'b1;
    drv = 8'h5A;
    #1;
    rst = 1'b1;
    #1;
    m_pc = '0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    chk("rst_data", data, 0);
    chk("rst_sp", sp, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_bus", bus, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_hold_data", data, 0);
    chk("rst_hold_sp", sp, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    call = 1'b0; ie = 1'b0; step = 1'b0; ret = 1'b0; clr_err = 1'b0;
    oe = 1'b0;
  endtask

  // Monitor: after every falling edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data", data, e.pc);
        chk("sp", sp, e.sp);
        chk("empty", empty, (e.sp == 0));
        chk("full", full, (e.sp == DEPTH));
        chk("overflow", overflow, e.ovf);
        chk("underflow", underflow, e.unf);
        chk("bus", bus, e.bv);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ie = 0; oe = 0; step = 0; call = 0; ret = 0; clr_err = 0;
    drv = '0;
    m_pc = '0; m_ovf = 0; m_unf = 0;
    #3;
    rst = 1'b1;
    #10;
    do_reset();

    // Step through the full address range and wrap.
    for (int n = 0; n < 256; n++) op(0, 0, 0, 1, 0, 0, 8'h00);

    // Jump, then drive onto the bus, then release it.
    op(0, 0, 1, 0, 0, 0, 8'h3C);
    idle(1'b1, 8'h00);
    idle(1'b0, 8'hA5);

    // Call and return.
    op(0, 0, 1, 0, 0, 0, 8'h10);
    op(0, 1, 0, 0, 0, 0, 8'h80);
    op(0, 0, 0, 1, 0, 0, 8'h00);
    op(0, 0, 0, 1, 0, 0, 8'h00);
    op(1, 0, 0, 0, 0, 0, 8'h00);

    // Nesting to full, overflow, then unwind.
    op(0, 0, 1, 0, 0, 0, 8'h01);
    op(0, 1, 0, 0, 0, 0, 8'h21);
    op(0, 1, 0, 0, 0, 0, 8'h41);
    op(0, 1, 0, 0, 0, 0, 8'h61);
    op(0, 1, 0, 0, 0, 0, 8'h80);
    op(0, 1, 0, 0, 0, 0, 8'hF0);
    for (int n = 0; n < 4; n++) op(1, 0, 0, 0, 0, 0, 8'h00);

    // Underflow, stickiness, clear, and set-wins-over-clear.
    op(1, 0, 0, 0, 0, 0, 8'h00);
    idle(1'b0, 8'h00);
    idle(1'b0, 8'h00);
    op(0, 0, 0, 0, 1, 0, 8'h00);
    op(1, 0, 0, 0, 1, 0, 8'h00);
    op(0, 0, 0, 0, 1, 0, 8'h00);

    // Priority resolution.
    op(0, 0, 1, 0, 0, 0, 8'h44);
    op(0, 1, 0, 0, 0, 0, 8'h99);
    op(1, 1, 1, 1, 0, 0, 8'h33);
    op(0, 0, 1, 1, 0, 0, 8'h07);

    // Call immediately followed by return.
    op(0, 1, 0, 0, 0, 1, 8'h00);
    op(1, 0, 0, 0, 0, 0, 8'h00);

    // Randomized traffic with occasional resets.
    for (int blk = 0; blk < 4; blk++) begin
      for (int n = 0; n < 500; n++) begin
        op(($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           8'($urandom));
      end
      do_reset();
    end

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
